// File: rtl/mat_core.sv
// Vector compute core of the matrix tile: fetch/exec FSM over 8 shortreal vector registers,
// private instruction/data memories and a blocking send/recv handshake to the switch.

module mat_core_inst_mem #(
  parameter int SIZE = 65536,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] inst_mem [SIZE];

  // Programs are preloaded hierarchically; the core ties the write port off.
  always_ff @(posedge clock)
    if (we) inst_mem[addr] <= wdata;

  assign rdata = inst_mem[addr];
endmodule

module mat_core_data_mem #(
  parameter int SIZE = 65536,
  parameter int W    = 16,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic        clock,
  input  logic        we,
  input  logic [31:0] base,
  input  shortreal    wdata [W],
  output shortreal    rdata [W]
);
  shortreal data_mem [SIZE];

  function automatic logic [AW-1:0] lane_addr(input logic [31:0] b, input int k);
    return AW'((b + 32'(k)) % 32'(SIZE));
  endfunction

  always_comb
    for (int k = 0; k < W; k++) rdata[k] = data_mem[lane_addr(base, k)];

  always_ff @(posedge clock)
    if (we)
      for (int k = 0; k < W; k++) data_mem[lane_addr(base, k)] <= wdata[k];
endmodule

module mat_core_lane (
  input  logic [1:0] sel,
  input  shortreal   a,
  input  shortreal   b,
  input  shortreal   s,
  output shortreal   y
);
  always_comb begin
    case (sel)
      2'd0:    y = a + b;
      2'd1:    y = a * b;
      default: y = a * s;
    endcase
  end
endmodule

module mat_core #(
  parameter int SWITCH_CORE_SIZE      = 4,
  parameter int SWITCH_WIDTH          = 16,
  parameter int INST_MEM_SIZE         = 65536,
  parameter int DATA_MEM_SIZE         = 65536,
  parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
  input  logic                             clock,
  input  logic                             reset,
  output logic                             done,
  output logic                             switch_send_ready,
  output logic [SWITCH_CORE_ADDR_SIZE-1:0] switch_send_core_idx,
  output shortreal                         switch_send_data [SWITCH_WIDTH],
  input  logic                             switch_send_ok,
  output logic                             switch_recv_request,
  output logic [SWITCH_CORE_ADDR_SIZE-1:0] switch_recv_core_idx,
  input  logic                             switch_recv_ready,
  input  shortreal                         switch_recv_data [SWITCH_WIDTH]
);
  localparam int PC_W = $clog2(INST_MEM_SIZE);

  localparam logic [5:0] OP_HALT = 6'd1, OP_LOAD = 6'd2, OP_STORE = 6'd3, OP_VADD = 6'd4,
                         OP_VMUL = 6'd5, OP_VSCALE = 6'd6, OP_SEND = 6'd7, OP_RECV = 6'd8;

  typedef enum logic [2:0] {FETCH, EXEC, SEND_WAIT, RECV_WAIT, HALTED} state_t;

  state_t          state;
  logic [PC_W-1:0] pc, pc_next;
  logic [31:0]     ir, inst_word;
  shortreal        vreg   [8][SWITCH_WIDTH];
  shortreal        ra_vec [SWITCH_WIDTH];
  shortreal        rb_vec [SWITCH_WIDTH];
  shortreal        lane_y [SWITCH_WIDTH];
  shortreal        dm_rdata [SWITCH_WIDTH];

  logic [5:0]  op;
  logic [2:0]  rd, ra, rb;
  logic [15:0] imm;
  logic        unused_ir16;

  assign op  = ir[31:26];
  assign rd  = ir[25:23];
  assign ra  = ir[22:20];
  assign rb  = ir[19:17];
  assign imm = ir[15:0];
  assign unused_ir16 = ir[16];

  assign pc_next = (pc == PC_W'(INST_MEM_SIZE - 1)) ? '0 : pc + 1'b1;

  always_comb
    for (int k = 0; k < SWITCH_WIDTH; k++) begin
      ra_vec[k] = vreg[ra][k];
      rb_vec[k] = vreg[rb][k];
    end

  mat_core_inst_mem #(.SIZE(INST_MEM_SIZE)) inst_mem (
    .clock(clock), .we(1'b0), .addr(pc), .wdata(32'd0), .rdata(inst_word)
  );

  mat_core_data_mem #(.SIZE(DATA_MEM_SIZE), .W(SWITCH_WIDTH)) data_mem (
    .clock(clock), .we(state == EXEC && op == OP_STORE), .base({16'd0, imm}),
    .wdata(ra_vec), .rdata(dm_rdata)
  );

  // VADD/VMUL/VSCALE differ only in op[1:0], which selects the lane function.
  for (genvar k = 0; k < SWITCH_WIDTH; k++) begin : g_lane
    mat_core_lane u_lane (
      .sel(op[1:0]), .a(ra_vec[k]), .b(rb_vec[k]), .s(rb_vec[0]), .y(lane_y[k])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= FETCH;
      pc                   <= '0;
      ir                   <= '0;
      done                 <= 1'b0;
      switch_send_ready    <= 1'b0;
      switch_send_core_idx <= '0;
      switch_recv_request  <= 1'b0;
      switch_recv_core_idx <= '0;
      for (int k = 0; k < SWITCH_WIDTH; k++) switch_send_data[k] <= 0.0;
      for (int r = 0; r < 8; r++)
        for (int k = 0; k < SWITCH_WIDTH; k++) vreg[r][k] <= 0.0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= inst_word;
          state <= EXEC;
        end
        EXEC: begin
          pc    <= pc_next;
          state <= FETCH;
          case (op)
            OP_HALT: begin
              done  <= 1'b1;
              state <= HALTED;
            end
            OP_LOAD:
              for (int k = 0; k < SWITCH_WIDTH; k++) vreg[rd][k] <= dm_rdata[k];
            OP_VADD, OP_VMUL, OP_VSCALE:
              for (int k = 0; k < SWITCH_WIDTH; k++) vreg[rd][k] <= lane_y[k];
            OP_SEND: begin
              switch_send_ready    <= 1'b1;
              switch_send_core_idx <= imm[SWITCH_CORE_ADDR_SIZE-1:0];
              for (int k = 0; k < SWITCH_WIDTH; k++) switch_send_data[k] <= ra_vec[k];
              state <= SEND_WAIT;
            end
            OP_RECV: begin
              switch_recv_request  <= 1'b1;
              switch_recv_core_idx <= imm[SWITCH_CORE_ADDR_SIZE-1:0];
              state <= RECV_WAIT;
            end
            default: ;
          endcase
        end
        SEND_WAIT:
          if (switch_send_ok) begin
            switch_send_ready <= 1'b0;
            state             <= FETCH;
          end
        RECV_WAIT:
          if (switch_recv_ready) begin
            for (int k = 0; k < SWITCH_WIDTH; k++) vreg[rd][k] <= switch_recv_data[k];
            switch_recv_request <= 1'b0;
            state               <= FETCH;
          end
        HALTED: ;
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mat_core.sv
// Bench for mat_core: preloads programs, checks vectors leaving the switch port against a
// scoreboard, and walks the handshake, reset and address-wrap corner cases.
module tb_mat_core;
  localparam int W = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       done, send_ready, send_ok, recv_request, recv_ready;
  logic [1:0] send_idx, recv_idx;
  shortreal   send_data [W];
  shortreal   recv_data [W];

  always #5 clock = ~clock;

  mat_core dut (
    .clock(clock), .reset(reset), .done(done),
    .switch_send_ready(send_ready), .switch_send_core_idx(send_idx),
    .switch_send_data(send_data), .switch_send_ok(send_ok),
    .switch_recv_request(recv_request), .switch_recv_core_idx(recv_idx),
    .switch_recv_ready(recv_ready), .switch_recv_data(recv_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [1:0] idx; shortreal d [W]; } exp_t;
  exp_t sb [$];

  // Table: operand ramps and the expected result as e0 + e1*k + e2*k*k.
  typedef struct {
    int op; shortreal a0, da, b0, db; int idx; shortreal e0, e1, e2;
  } vec_t;
  vec_t tbl [4];

  function automatic logic [31:0] enc(input int op, input int rd, input int ra,
                                      input int rb, input int imm);
    return {op[5:0], rd[2:0], ra[2:0], rb[2:0], 1'b0, imm[15:0]};
  endfunction

  task automatic chk_int(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input shortreal act [W], input shortreal exp [W]);
    int bad = -1;
    n_cmp++;
    for (int k = 0; k < W; k++) if (bad < 0 && act[k] != exp[k]) bad = k;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s: lane %0d got %f, want %f", name, bad, act[bad], exp[bad]);
    end
  endtask

  task automatic put_inst(input int a, input logic [31:0] w);
    dut.inst_mem.inst_mem[a] = w;
  endtask

  task automatic put_data(input int a, input shortreal v);
    dut.data_mem.data_mem[a % 65536] = v;
  endtask

  task automatic get_data(input int base, output shortreal v [W]);
    for (int k = 0; k < W; k++) v[k] = dut.data_mem.data_mem[(base + k) % 65536];
  endtask

  task automatic enter_reset();
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!done && n < 200) begin @(posedge clock); #1; n++; end
    chk_int({name, " done"}, done, 1);
  endtask

  // Waits for an offered vector, checks it against the scoreboard head, then accepts it.
  task automatic check_send(input string name);
    int   n = 0;
    exp_t e;
    while (!send_ready && n < 100) begin @(posedge clock); #1; n++; end
    if (!send_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: send_ready timeout, got 0, want 1", name);
      return;
    end
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: unexpected send, got 1 vector, want 0", name);
      return;
    end
    e = sb.pop_front();
    chk_int({name, " idx"}, send_idx, e.idx);
    chk_vec({name, " data"}, send_data, e.d);
    send_ok = 1'b1;
    @(posedge clock); #1;
    send_ok = 1'b0;
    chk_int({name, " ready drop"}, send_ready, 0);
  endtask

  initial begin
    shortreal zero [W];
    shortreal v    [W];
    exp_t     e;
    int       n;

    tbl[0] = '{4, 2.0,  1.0,   0.5, 1.0, 1, 2.5, 2.0,  0.0};
    tbl[1] = '{5, 2.0,  1.0,   0.5, 1.0, 3, 1.0, 2.5,  1.0};
    tbl[2] = '{6, 1.0,  1.0,   3.0, 2.0, 2, 3.0, 3.0,  0.0};
    tbl[3] = '{4, -1.5, -0.25, 4.0, 0.5, 0, 2.5, 0.25, 0.0};

    for (int k = 0; k < W; k++) begin zero[k] = 0.0; recv_data[k] = 0.0; end
    send_ok = 1'b0; recv_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk_int("rst done", done, 0);
    chk_int("rst send_ready", send_ready, 0);
    chk_int("rst recv_request", recv_request, 0);
    chk_int("rst idx", {send_idx, recv_idx}, 0);
    chk_vec("rst send_data", send_data, zero);

    // LOAD / STORE / HALT, with exact HALT latency
    for (int k = 0; k < W; k++) put_data(k, shortreal'(k + 1));
    put_inst(0, enc(2, 0, 0, 0, 0));
    put_inst(1, enc(3, 0, 0, 0, 100));
    put_inst(2, enc(1, 0, 0, 0, 0));
    reset = 1'b0;
    wait_done("ldst", n);
    chk_int("ldst cycles", n, 6);
    get_data(100, v);
    for (int k = 0; k < W; k++) e.d[k] = shortreal'(k + 1);
    chk_vec("ldst mem", v, e.d);
    repeat (5) @(posedge clock);
    #1;
    chk_int("ldst done sticky", done, 1);

    // Table-driven vector ops observed through SEND
    for (int t = 0; t < 4; t++) begin
      enter_reset();
      for (int k = 0; k < W; k++) begin
        put_data(k,      tbl[t].a0 + tbl[t].da * shortreal'(k));
        put_data(16 + k, tbl[t].b0 + tbl[t].db * shortreal'(k));
        e.d[k] = tbl[t].e0 + tbl[t].e1 * shortreal'(k) + tbl[t].e2 * shortreal'(k * k);
      end
      e.idx = tbl[t].idx[1:0];
      sb.push_back(e);
      put_inst(0, enc(2, 1, 0, 0, 0));
      put_inst(1, enc(2, 2, 0, 0, 16));
      put_inst(2, enc(tbl[t].op, 3, 1, 2, 0));
      put_inst(3, enc(7, 0, 3, 0, tbl[t].idx));
      put_inst(4, enc(1, 0, 0, 0, 0));
      reset = 1'b0;
      check_send($sformatf("vec%0d", t));
      wait_done($sformatf("vec%0d", t), n);
    end

    // SEND held while ok stays low
    enter_reset();
    for (int k = 0; k < W; k++) begin put_data(k, shortreal'(10 + k)); e.d[k] = shortreal'(10 + k); end
    put_inst(0, enc(2, 4, 0, 0, 0));
    put_inst(1, enc(7, 0, 4, 0, 3));
    put_inst(2, enc(1, 0, 0, 0, 0));
    reset = 1'b0;
    n = 0;
    while (!send_ready && n < 100) begin @(posedge clock); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      chk_int($sformatf("hold ready c%0d", c), send_ready, 1);
      chk_int($sformatf("hold idx c%0d", c), send_idx, 3);
      chk_vec($sformatf("hold data c%0d", c), send_data, e.d);
      @(posedge clock); #1;
    end
    send_ok = 1'b1;
    @(posedge clock); #1;
    send_ok = 1'b0;
    chk_int("hold ready drop", send_ready, 0);
    wait_done("hold", n);

    // RECV from core 2 with a delayed ready
    enter_reset();
    put_inst(0, enc(8, 5, 0, 0, 2));
    put_inst(1, enc(3, 0, 5, 0, 200));
    put_inst(2, enc(1, 0, 0, 0, 0));
    reset = 1'b0;
    n = 0;
    while (!recv_request && n < 100) begin @(posedge clock); #1; n++; end
    chk_int("recv idx", recv_idx, 2);
    repeat (3) begin
      @(posedge clock); #1;
      chk_int("recv request held", recv_request, 1);
    end
    for (int k = 0; k < W; k++) begin recv_data[k] = 7.5; e.d[k] = 7.5; end
    recv_ready = 1'b1;
    @(posedge clock); #1;
    recv_ready = 1'b0;
    for (int k = 0; k < W; k++) recv_data[k] = 0.0;
    chk_int("recv request drop", recv_request, 0);
    wait_done("recv", n);
    get_data(200, v);
    chk_vec("recv mem", v, e.d);

    // Reset during SEND_WAIT; restart with a program that sends a cleared register
    enter_reset();
    for (int k = 0; k < W; k++) put_data(k, shortreal'(20 + k));
    put_inst(0, enc(2, 6, 0, 0, 0));
    put_inst(1, enc(7, 0, 6, 0, 1));
    put_inst(2, enc(1, 0, 0, 0, 0));
    reset = 1'b0;
    n = 0;
    while (!send_ready && n < 100) begin @(posedge clock); #1; n++; end
    chk_int("midrst pre ready", send_ready, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_int("midrst ready", send_ready, 0);
    chk_int("midrst idx", send_idx, 0);
    chk_vec("midrst data", send_data, zero);
    chk_int("midrst done", done, 0);
    put_inst(0, enc(7, 0, 6, 0, 2));
    put_inst(1, enc(1, 0, 0, 0, 0));
    reset = 1'b0;
    n = 0;
    while (!send_ready && n < 100) begin @(posedge clock); #1; n++; end
    chk_int("midrst restart cycles", n, 2);
    e.idx = 2'd2;
    e.d   = zero;
    sb.push_back(e);
    check_send("midrst vreg cleared");
    wait_done("midrst", n);

    // Undefined opcode, then LOAD across the data address wrap
    enter_reset();
    for (int k = 0; k < W; k++) begin
      put_data(65530 + k, shortreal'(100 + k));
      e.d[k] = shortreal'(100 + k);
    end
    e.idx = 2'd0;
    sb.push_back(e);
    put_inst(0, enc(63, 1, 1, 1, 0));
    put_inst(1, enc(2, 1, 0, 0, 65530));
    put_inst(2, enc(7, 0, 1, 0, 0));
    put_inst(3, enc(1, 0, 0, 0, 0));
    reset = 1'b0;
    check_send("wrap");
    wait_done("wrap", n);
    chk_int("scoreboard empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
